// File: rtl/conv_frame_sequencer_if.sv
// Control/status bundle between the frame sequencer and its surroundings.
// The sequencer sits on the slave side and the controller on the master side.
interface conv_frame_sequencer_if #(
    parameter int AW = 15
);
    logic          start;
    logic [1:0]    kernel_sel_in;
    logic          stall;
    logic [1:0]    kernel_select;
    logic [AW-1:0] raddr_alu;
    logic          issue_valid;
    logic          fb_wen;
    logic          fb_edge;
    logic          busy;
    logic          done;

    modport master (
        output start, kernel_sel_in, stall,
        input  kernel_select, raddr_alu, issue_valid, fb_wen, fb_edge, busy, done
    );

    modport slave (
        input  start, kernel_sel_in, stall,
        output kernel_select, raddr_alu, issue_valid, fb_wen, fb_edge, busy, done
    );
endinterface

// File: rtl/conv_frame_sequencer.sv
// Walks one image in raster order per start, issuing a centre-pixel address per cycle to the
// 5x5 convolution ALU and re-timing write strobe / border flag to the ALU output latency.
module conv_frame_sequencer #(
    parameter int H_RES   = 160,
    parameter int V_RES   = 120,
    parameter int AW      = 15,
    parameter int ALU_LAT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    conv_frame_sequencer_if.slave bus
);
    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int DW = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;

    localparam logic [XW-1:0] X_LAST     = XW'(H_RES - 1);
    localparam logic [XW-1:0] X_BORDER_H = XW'(H_RES - 2);
    localparam logic [XW-1:0] X_BORDER_L = XW'(2);
    localparam logic [YW-1:0] Y_LAST     = YW'(V_RES - 1);
    localparam logic [YW-1:0] Y_BORDER_H = YW'(V_RES - 2);
    localparam logic [YW-1:0] Y_BORDER_L = YW'(2);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(ALU_LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [XW-1:0]       x;
    logic [YW-1:0]       y;
    logic [AW-1:0]       raddr;
    logic [1:0]          kernel_q;
    logic [DW-1:0]       drain_cnt;
    logic [ALU_LAT-1:0]  pipe_wen;
    logic [ALU_LAT-1:0]  pipe_edge;
    logic                issue;
    logic                accept;
    logic                last_pix;
    logic                edge_flag;

    assign last_pix  = (x == X_LAST) && (y == Y_LAST);
    assign edge_flag = (x < X_BORDER_L) || (x >= X_BORDER_H) ||
                       (y < Y_BORDER_L) || (y >= Y_BORDER_H);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!bus.stall) begin
                    issue = 1'b1;
                    if (last_pix) state_nxt = DRAIN;
                end
            end
            DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Raster order makes the address a plain increment, so no multiplier is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            raddr     <= '0;
            kernel_q  <= '0;
            drain_cnt <= '0;
        end else begin
            if (accept) begin
                x        <= '0;
                y        <= '0;
                raddr    <= '0;
                kernel_q <= bus.kernel_sel_in;
            end else if (issue) begin
                if (last_pix) begin
                    x     <= '0;
                    y     <= '0;
                    raddr <= '0;
                end else if (x == X_LAST) begin
                    x     <= '0;
                    y     <= y + 1'b1;
                    raddr <= raddr + 1'b1;
                end else begin
                    x     <= x + 1'b1;
                    raddr <= raddr + 1'b1;
                end
            end
            if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
            else                drain_cnt <= '0;
        end
    end

    // The latency pipe shifts every cycle so stall bubbles reach the write side as gaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_wen  <= '0;
            pipe_edge <= '0;
        end else begin
            pipe_wen[0]  <= issue;
            pipe_edge[0] <= issue & edge_flag;
            for (int i = 1; i < ALU_LAT; i++) begin
                pipe_wen[i]  <= pipe_wen[i-1];
                pipe_edge[i] <= pipe_edge[i-1];
            end
        end
    end

    assign bus.issue_valid   = issue;
    assign bus.raddr_alu     = raddr;
    assign bus.kernel_select = kernel_q;
    assign bus.fb_wen        = pipe_wen[ALU_LAT-1];
    assign bus.fb_edge       = pipe_edge[ALU_LAT-1];
    assign bus.busy          = (state == RUN) || (state == DRAIN);
    assign bus.done          = (state == DONE);
endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Scoreboard bench for conv_frame_sequencer on an 8x6 image with a 3-cycle ALU latency.
// Stimulus pushes expected issue/write events; a negedge monitor pops and compares them.
module tb_conv_frame_sequencer;
    localparam int H  = 8;
    localparam int V  = 6;
    localparam int NP = H * V;
    localparam int LAT = 3;

    typedef struct {
        int cyc;
        int addr;
        int edge_f;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   tick = 0;
    int   total = 0;
    int   bad = 0;

    ev_t  exp_issue[$];
    ev_t  exp_wen[$];
    int   base = 0;
    int   exp_k = 0;
    int   exp_done_cur = 0;
    bit   active = 1'b0;
    int   wen_cnt, interior_cnt, done_seen, last_issue_rel;
    int   wr_edge[NP];

    conv_frame_sequencer_if #(.AW(6)) bus ();

    conv_frame_sequencer #(
        .H_RES(H), .V_RES(V), .AW(6), .ALU_LAT(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tick <= tick + 1;

    task automatic check_output(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (tick %0d)", name, actual, expected, tick);
        end
    endtask

    function automatic int edge_of(input int a);
        int x;
        int y;
        x = a % H;
        y = a / H;
        return (x < 2 || x >= H - 2 || y < 2 || y >= V - 2) ? 1 : 0;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents an issue, a write or done.
    always @(negedge clk) begin
        ev_t e;
        int  rel;
        rel = tick - base;
        check_output("busy", int'(bus.busy), (active && rel >= 1 && rel < exp_done_cur) ? 1 : 0);
        if (bus.issue_valid) begin
            if (exp_issue.size() == 0) begin
                check_output("issue_unexpected", int'(bus.issue_valid), 0);
            end else begin
                e = exp_issue.pop_front();
                check_output("issue_cycle", rel, e.cyc - base);
                check_output("raddr", int'(bus.raddr_alu), e.addr);
                check_output("kernel_select", int'(bus.kernel_select), exp_k);
                last_issue_rel = rel;
            end
        end
        if (bus.fb_wen) begin
            if (exp_wen.size() == 0) begin
                check_output("wen_unexpected", int'(bus.fb_wen), 0);
            end else begin
                e = exp_wen.pop_front();
                check_output("wen_cycle", rel, e.cyc - base);
                check_output("fb_edge", int'(bus.fb_edge), e.edge_f);
                wr_edge[e.addr] = int'(bus.fb_edge);
                wen_cnt++;
                if (!bus.fb_edge) interior_cnt++;
            end
        end
        if (bus.done) begin
            if (!active) begin
                check_output("done_unexpected", int'(bus.done), 0);
            end else begin
                check_output("done_cycle", rel, exp_done_cur);
                done_seen++;
            end
        end
    end

    task automatic apply_stimulus(input int ks, input int st_lo, input int st_hi, input int rep,
                                  input int abort_at, input bit b2b, input int exp_done,
                                  input int exp_last);
        int addr;
        int c;
        int last_rel;
        @(posedge clk);
        #1;
        bus.start         = 1'b1;
        bus.kernel_sel_in = 2'(ks);
        bus.stall         = 1'b0;
        base           = tick;
        exp_k          = ks;
        exp_done_cur   = (abort_at > 0) ? 1000 : exp_done;
        wen_cnt        = 0;
        interior_cnt   = 0;
        done_seen      = 0;
        last_issue_rel = -1;
        for (int i = 0; i < NP; i++) wr_edge[i] = -1;
        addr = 0;
        c    = 1;
        while (addr < NP) begin
            if (!(c >= st_lo && c <= st_hi)) begin
                exp_issue.push_back('{base + c, addr, 0});
                exp_wen.push_back('{base + c + LAT, addr, edge_of(addr)});
                addr++;
            end
            c++;
        end
        active   = 1'b1;
        last_rel = (abort_at > 0) ? abort_at : exp_done;
        for (int rel = 1; rel <= last_rel; rel++) begin
            @(posedge clk);
            #1;
            bus.start = (rel == rep) || (b2b && rel == exp_done);
            bus.kernel_sel_in = (rel == rep) ? 2'd1 : ((b2b && rel == exp_done) ? 2'd3 : 2'(ks));
            bus.stall = (rel >= st_lo && rel <= st_hi);
            if (rel == abort_at) begin
                rst = 1'b1;
                #1;
                check_output("abort_issue_valid", int'(bus.issue_valid), 0);
                check_output("abort_fb_wen", int'(bus.fb_wen), 0);
                check_output("abort_fb_edge", int'(bus.fb_edge), 0);
                check_output("abort_busy", int'(bus.busy), 0);
                check_output("abort_done", int'(bus.done), 0);
                check_output("abort_raddr", int'(bus.raddr_alu), 0);
                check_output("abort_kernel", int'(bus.kernel_select), 0);
                exp_issue.delete();
                exp_wen.delete();
                active = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
            if (bus.stall) begin
                #1;
                check_output("stall_raddr_hold", int'(bus.raddr_alu), st_lo - 1);
                check_output("stall_issue_valid", int'(bus.issue_valid), 0);
            end
        end
        @(negedge clk);
        #1;
        check_output("done_count", done_seen, 1);
        check_output("wen_count", wen_cnt, NP);
        check_output("interior_count", interior_cnt, 8);
        check_output("last_issue_cycle", last_issue_rel, exp_last);
        check_output("issue_leftover", exp_issue.size(), 0);
        check_output("wen_leftover", exp_wen.size(), 0);
        check_output("edge_addr18", wr_edge[18], 0);
        check_output("edge_addr29", wr_edge[29], 0);
        check_output("edge_addr0", wr_edge[0], 1);
        check_output("edge_addr7", wr_edge[7], 1);
        check_output("edge_addr40", wr_edge[40], 1);
        check_output("edge_addr47", wr_edge[47], 1);
        check_output("edge_addr30", wr_edge[30], 1);
        active = 1'b0;
    endtask

    initial begin
        rst               = 1'b0;
        bus.start         = 1'b0;
        bus.kernel_sel_in = 2'd0;
        bus.stall         = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check_output("reset_issue_valid", int'(bus.issue_valid), 0);
        check_output("reset_raddr", int'(bus.raddr_alu), 0);
        check_output("reset_kernel", int'(bus.kernel_select), 0);
        check_output("reset_fb_wen", int'(bus.fb_wen), 0);
        check_output("reset_fb_edge", int'(bus.fb_edge), 0);
        check_output("reset_busy", int'(bus.busy), 0);
        check_output("reset_done", int'(bus.done), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] pass 1: no stall, kernel 2, start held into DONE");
        apply_stimulus(2, -1, -1, -1, -1, 1'b1, 52, 48);
        $display("[TB] pass 2: back-to-back start, stall 10..12, start re-pulse at 20");
        apply_stimulus(2, 10, 12, 20, -1, 1'b0, 55, 51);
        $display("[TB] pass 3: async reset at cycle 30");
        apply_stimulus(3, -1, -1, -1, 30, 1'b0, 52, 48);
        $display("[TB] pass 4: full pass after reset, kernel 1");
        apply_stimulus(1, -1, -1, -1, -1, 1'b0, 52, 48);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
